// File: rtl/c64_kbd_pkg.sv
// Shared definitions for the C64 keyboard matrix emulation.
//  - parse_state_t : PS/2 set-2 scancode parser states
//  - SC_*          : prefix, BAT/ack and special scancode bytes
//  - is_bat(), is_fake_shift() : byte classifiers used by the parser
//  - scancode_to_matrix(ext, code) -> {valid, col[2:0], row[2:0]}
//    col is the CIA1 port A bit, row is the CIA1 port B bit.
package c64_kbd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } parse_state_t;

  localparam logic [7:0] SC_E0      = 8'hE0;
  localparam logic [7:0] SC_F0      = 8'hF0;
  localparam logic [7:0] SC_E1      = 8'hE1;
  localparam logic [7:0] SC_AA      = 8'hAA;
  localparam logic [7:0] SC_FA      = 8'hFA;
  localparam logic [7:0] SC_FE      = 8'hFE;
  localparam logic [7:0] SC_EE      = 8'hEE;
  localparam logic [7:0] SC_LSHIFT  = 8'h12;
  localparam logic [7:0] SC_RSHIFT  = 8'h59;
  localparam logic [7:0] SC_RESTORE = 8'h7D;  // with E0 prefix (PgUp)

  // Self-test, ack, resend, echo and pause prefix bytes carry no key event.
  function automatic logic is_bat(input logic [7:0] code);
    return (code == SC_AA) || (code == SC_FA) || (code == SC_FE) ||
           (code == SC_EE) || (code == SC_E1);
  endfunction

  // Keyboards wrap extended keys in fake shift make/break codes.
  function automatic logic is_fake_shift(input logic [7:0] code);
    return (code == SC_LSHIFT) || (code == SC_RSHIFT);
  endfunction

  function automatic logic [6:0] kc(input int c, input int r);
    return {1'b1, 3'(c), 3'(r)};
  endfunction

  function automatic logic [6:0] scancode_to_matrix(input logic ext, input logic [7:0] code);
    logic [6:0] m;
    m = 7'd0;
    case ({ext, code})
      // column 0: DEL RETURN CRSR-RT F7 F1 F3 F5 CRSR-DN
      9'h066: m = kc(0, 0);  9'h05A: m = kc(0, 1);  9'h174: m = kc(0, 2);  9'h083: m = kc(0, 3);
      9'h005: m = kc(0, 4);  9'h004: m = kc(0, 5);  9'h003: m = kc(0, 6);  9'h172: m = kc(0, 7);
      // column 1: 3 W A 4 Z S E LSHIFT
      9'h026: m = kc(1, 0);  9'h01D: m = kc(1, 1);  9'h01C: m = kc(1, 2);  9'h025: m = kc(1, 3);
      9'h01A: m = kc(1, 4);  9'h01B: m = kc(1, 5);  9'h024: m = kc(1, 6);  9'h012: m = kc(1, 7);
      // column 2: 5 R D 6 C F T X
      9'h02E: m = kc(2, 0);  9'h02D: m = kc(2, 1);  9'h023: m = kc(2, 2);  9'h036: m = kc(2, 3);
      9'h021: m = kc(2, 4);  9'h02B: m = kc(2, 5);  9'h02C: m = kc(2, 6);  9'h022: m = kc(2, 7);
      // column 3: 7 Y G 8 B H U V
      9'h03D: m = kc(3, 0);  9'h035: m = kc(3, 1);  9'h034: m = kc(3, 2);  9'h03E: m = kc(3, 3);
      9'h032: m = kc(3, 4);  9'h033: m = kc(3, 5);  9'h03C: m = kc(3, 6);  9'h02A: m = kc(3, 7);
      // column 4: 9 I J 0 M K O N
      9'h046: m = kc(4, 0);  9'h043: m = kc(4, 1);  9'h03B: m = kc(4, 2);  9'h045: m = kc(4, 3);
      9'h03A: m = kc(4, 4);  9'h042: m = kc(4, 5);  9'h044: m = kc(4, 6);  9'h031: m = kc(4, 7);
      // column 5: + P L - . : @ ,   (= -> +, ' -> :, [ -> @)
      9'h055: m = kc(5, 0);  9'h04D: m = kc(5, 1);  9'h04B: m = kc(5, 2);  9'h04E: m = kc(5, 3);
      9'h049: m = kc(5, 4);  9'h052: m = kc(5, 5);  9'h054: m = kc(5, 6);  9'h041: m = kc(5, 7);
      // column 6: pound * ; HOME RSHIFT /   (\ -> pound, ] -> *)
      9'h05D: m = kc(6, 0);  9'h05B: m = kc(6, 1);  9'h04C: m = kc(6, 2);  9'h16C: m = kc(6, 3);
      9'h059: m = kc(6, 4);  9'h04A: m = kc(6, 7);
      // column 7: 1 <- CTRL 2 SPACE C= Q RUN/STOP   (` -> <-, TAB/LGUI -> C=, ESC -> RUN/STOP)
      9'h016: m = kc(7, 0);  9'h00E: m = kc(7, 1);  9'h014: m = kc(7, 2);  9'h114: m = kc(7, 2);
      9'h01E: m = kc(7, 3);  9'h029: m = kc(7, 4);  9'h00D: m = kc(7, 5);  9'h11F: m = kc(7, 5);
      9'h015: m = kc(7, 6);  9'h076: m = kc(7, 7);
      default: m = 7'd0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/kbd_scancode_fifo.sv
// Scancode byte FIFO, DEPTH x 8 (DEPTH a power of two).
// Ports: clk, res_n (async, active low), push/wr_data, pop/rd_data
// (head byte presented combinationally), full, empty.
// Push while full is only legal together with a pop.
module kbd_scancode_fifo #(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       push,
  input  logic [7:0] wr_data,
  input  logic       pop,
  output logic [7:0] rd_data,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [AW:0]   count_reg;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wr_data;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   count_reg <= count_reg + (AW+1)'(1);
        2'b01:   count_reg <= count_reg - (AW+1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign rd_data = mem[rd_ptr_reg];
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
endmodule

// File: rtl/c64_keyboard_matrix.sv
// C64 8x8 keyboard matrix + joystick merge for CIA1 ports A/B, fed by PS/2
// set-2 scancode bytes. Also drives the RESTORE line (E0 7D) for NMI logic.
// Ports: clk, res_n (async, active low), phi2_p (phi2 strobe),
//   ps2_byte/ps2_valid (scancode in), fifo_ovf (byte dropped pulse),
//   pa_out/pa_oe, pb_out/pb_oe (CIA1 drive), joy2_n/joy1_n (active low,
//   {fire,right,left,down,up}), pa_in/pb_in (pin levels), restore_n.
// Build option: define KBD_GHOSTING_EN to model one level of key ghosting
// (three pressed keys on a rectangle make the fourth corner appear).
module c64_keyboard_matrix
  import c64_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int HOLD_TICKS = 400
) (
  input  logic       clk,
  input  logic       res_n,
  input  logic       phi2_p,
  input  logic [7:0] ps2_byte,
  input  logic       ps2_valid,
  output logic       fifo_ovf,
  input  logic [7:0] pa_out,
  input  logic [7:0] pa_oe,
  input  logic [7:0] pb_out,
  input  logic [7:0] pb_oe,
  input  logic [4:0] joy2_n,
  input  logic [4:0] joy1_n,
  output logic [7:0] pa_in,
  output logic [7:0] pb_in,
  output logic       restore_n
);
  localparam int HW = $clog2(HOLD_TICKS + 1);

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0]      fifo_data;
  parse_state_t    state_reg, state_next;
  logic [HW-1:0]   hold_reg;
  logic [7:0][7:0] key_reg;          // [col][row], 1 = pressed
  logic [7:0][7:0] key_t;            // transposed view: [row][col]
  logic            restore_reg, ovf_reg;
  logic [7:0]      pa_in_reg, pb_in_reg;

  logic            apply_en, apply_ext, apply_press;
  logic [6:0]      map_res;
  logic [2:0]      map_col, map_row;
  logic            is_restore, key_set, restore_set;

  // A byte arriving while full is still accepted if a pop frees a slot.
  assign fifo_push = ps2_valid & (~fifo_full | fifo_pop);

  kbd_scancode_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .res_n   (res_n),
    .push    (fifo_push),
    .wr_data (ps2_byte),
    .pop     (fifo_pop),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Parser: consumes one byte per clk once the hold window has expired.
  always_comb begin
    state_next  = state_reg;
    fifo_pop    = 1'b0;
    apply_en    = 1'b0;
    apply_ext   = 1'b0;
    apply_press = 1'b1;
    if (!fifo_empty && hold_reg == '0) begin
      fifo_pop = 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (fifo_data == SC_E0)      state_next = ST_EXT;
          else if (fifo_data == SC_F0) state_next = ST_BRK;
          else if (!is_bat(fifo_data)) apply_en   = 1'b1;
        end
        ST_EXT: begin
          if (fifo_data == SC_F0) begin
            state_next = ST_EXT_BRK;
          end else begin
            state_next = ST_IDLE;
            if (!is_fake_shift(fifo_data)) begin
              apply_en  = 1'b1;
              apply_ext = 1'b1;
            end
          end
        end
        ST_BRK: begin
          state_next  = ST_IDLE;
          apply_en    = 1'b1;
          apply_press = 1'b0;
        end
        default: begin  // ST_EXT_BRK
          state_next = ST_IDLE;
          if (!is_fake_shift(fifo_data)) begin
            apply_en    = 1'b1;
            apply_ext   = 1'b1;
            apply_press = 1'b0;
          end
        end
      endcase
    end
  end

  assign map_res    = scancode_to_matrix(apply_ext, fifo_data);
  assign map_col    = map_res[5:3];
  assign map_row    = map_res[2:0];
  assign is_restore = apply_ext && (fifo_data == SC_RESTORE);
  // Only an actual state change counts: typematic repeats produce no hold.
  assign key_set     = apply_en && !is_restore && map_res[6] &&
                       (key_reg[map_col][map_row] != apply_press);
  assign restore_set = apply_en && is_restore && (restore_reg != apply_press);

  // Matrix read path.
  logic [7:0] col_lo, row_lo, col_lo_p, row_lo_p, pa_kbd, pb_kbd;
  assign col_lo = pa_oe & ~pa_out;
  assign row_lo = pb_oe & ~pb_out;

  genvar gi, gj;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_tr_row
      for (gj = 0; gj < 8; gj++) begin : g_tr_col
        assign key_t[gi][gj] = key_reg[gj][gi];
      end
    end
  endgenerate

`ifdef KBD_GHOSTING_EN
  // Rows pulled low by driven columns, then columns pulled low by those rows.
  logic [7:0] rows_hit, cols_hit;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_rows_hit
      assign rows_hit[gi] = |(key_t[gi] & col_lo);
    end
  endgenerate
  assign row_lo_p = row_lo | rows_hit;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_cols_hit
      assign cols_hit[gi] = |(key_reg[gi] & row_lo_p);
    end
  endgenerate
  assign col_lo_p = col_lo | cols_hit;
`else
  assign row_lo_p = row_lo;
  assign col_lo_p = col_lo;
`endif

  generate
    for (gi = 0; gi < 8; gi++) begin : g_kbd
      assign pb_kbd[gi] = ~|(key_t[gi] & col_lo_p);
      assign pa_kbd[gi] = ~|(key_reg[gi] & row_lo_p);
    end
  endgenerate

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_reg   <= ST_IDLE;
      key_reg     <= '0;
      restore_reg <= 1'b0;
      hold_reg    <= '0;
      ovf_reg     <= 1'b0;
      pa_in_reg   <= 8'hFF;
      pb_in_reg   <= 8'hFF;
    end else begin
      state_reg <= state_next;
      if (key_set)     key_reg[map_col][map_row] <= apply_press;
      if (restore_set) restore_reg <= apply_press;
      if (key_set || restore_set)
        hold_reg <= HW'(HOLD_TICKS);
      else if (phi2_p && hold_reg != '0)
        hold_reg <= hold_reg - HW'(1);
      ovf_reg   <= ps2_valid & ~fifo_push;
      pa_in_reg <= (pa_out | ~pa_oe) & pa_kbd & {3'b111, joy2_n};
      pb_in_reg <= (pb_out | ~pb_oe) & pb_kbd & {3'b111, joy1_n};
    end
  end

  assign pa_in     = pa_in_reg;
  assign pb_in     = pb_in_reg;
  assign restore_n = ~restore_reg;
  assign fifo_ovf  = ovf_reg;
endmodule

// File: tb/tb_c64_keyboard_matrix.sv
// Bench for c64_keyboard_matrix: behavioural model (byte queue, prefix flags,
// key set, hold timer) checked against the DUT every cycle, plus literal
// expectations at the interesting points of each directed scenario.
module tb_c64_keyboard_matrix;
  localparam int FD   = 8;
  localparam int HOLD = 24;

  logic       clk = 1'b0;
  logic       res_n = 1'b0;
  logic       phi2_p = 1'b0;
  logic [7:0] ps2_byte = 8'h00;
  logic       ps2_valid = 1'b0;
  logic       fifo_ovf;
  logic [7:0] pa_out = 8'hFF, pa_oe = 8'h00, pb_out = 8'hFF, pb_oe = 8'h00;
  logic [4:0] joy2_n = 5'h1F, joy1_n = 5'h1F;
  logic [7:0] pa_in, pb_in;
  logic       restore_n;

  c64_keyboard_matrix #(.FIFO_DEPTH(FD), .HOLD_TICKS(HOLD)) dut (
    .clk(clk), .res_n(res_n), .phi2_p(phi2_p),
    .ps2_byte(ps2_byte), .ps2_valid(ps2_valid), .fifo_ovf(fifo_ovf),
    .pa_out(pa_out), .pa_oe(pa_oe), .pb_out(pb_out), .pb_oe(pb_oe),
    .joy2_n(joy2_n), .joy1_n(joy1_n),
    .pa_in(pa_in), .pb_in(pb_in), .restore_n(restore_n)
  );

  always #5 clk = ~clk;

  initial begin : p_phi2
    int n = 0;
    forever begin
      @(negedge clk);
      phi2_p = (n % 4 == 0);
      n++;
    end
  end

  // ---------------- behavioural model ----------------
  logic [7:0] q[$];
  bit         m_key[8][8];
  bit         m_restore = 0;
  int         m_hold = 0;
  bit         m_ext = 0, m_brk = 0;
  logic [7:0] exp_pa = 8'hFF, exp_pb = 8'hFF;
  logic       exp_ovf = 1'b0, exp_rst_n = 1'b1;
  int         kmap[int];

  initial begin
    kmap['h01C] = 1*8 + 2;  // A
    kmap['h01D] = 1*8 + 1;  // W
    kmap['h025] = 1*8 + 3;  // 4
    kmap['h03B] = 4*8 + 2;  // J
    kmap['h01A] = 1*8 + 4;  // Z
  end

  task automatic apply_evt(input bit ext, input logic [7:0] b, input bit press, output bit chg);
    int k;
    chg = 0;
    if (ext && b == 8'h7D) begin
      chg = (m_restore != press);
      m_restore = press;
    end else if (kmap.exists(int'({ext, b}))) begin
      k = kmap[int'({ext, b})];
      chg = (m_key[k/8][k%8] != press);
      m_key[k/8][k%8] = press;
    end
  endtask

  always @(posedge clk) begin : p_model
    logic [7:0] b, cl, rl, pak, pbk;
    bit chg, can_pop;
    if (!res_n) begin
      q.delete();
      foreach (m_key[c, r]) m_key[c][r] = 0;
      m_restore = 0; m_hold = 0; m_ext = 0; m_brk = 0;
      exp_pa = 8'hFF; exp_pb = 8'hFF; exp_ovf = 1'b0; exp_rst_n = 1'b1;
    end else begin
      cl = pa_oe & ~pa_out;
      rl = pb_oe & ~pb_out;
`ifdef KBD_GHOSTING_EN
      foreach (m_key[c, r]) if (m_key[c][r] && cl[c]) rl[r] = 1'b1;
      foreach (m_key[c, r]) if (m_key[c][r] && rl[r]) cl[c] = 1'b1;
`endif
      pak = 8'hFF; pbk = 8'hFF;
      foreach (m_key[c, r]) if (m_key[c][r]) begin
        if (cl[c]) pbk[r] = 1'b0;
        if (rl[r]) pak[c] = 1'b0;
      end
      exp_pa = (pa_out | ~pa_oe) & pak & {3'b111, joy2_n};
      exp_pb = (pb_out | ~pb_oe) & pbk & {3'b111, joy1_n};

      chg = 0;
      can_pop = (q.size() > 0) && (m_hold == 0);
      if (can_pop) begin
        b = q.pop_front();
        if (m_brk) begin
          if (!(m_ext && (b == 8'h12 || b == 8'h59))) apply_evt(m_ext, b, 0, chg);
          m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
          if (b == 8'hF0) m_brk = 1;
          else begin
            if (b != 8'h12 && b != 8'h59) apply_evt(1, b, 1, chg);
            m_ext = 0;
          end
        end else begin
          if (b == 8'hE0) m_ext = 1;
          else if (b == 8'hF0) m_brk = 1;
          else if (!(b inside {8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1})) apply_evt(0, b, 1, chg);
        end
      end
      exp_ovf = 1'b0;
      if (ps2_valid) begin
        if (q.size() < FD) q.push_back(ps2_byte);
        else exp_ovf = 1'b1;
      end
      if (chg) m_hold = HOLD;
      else if (phi2_p && m_hold > 0) m_hold--;
      exp_rst_n = !m_restore;
    end
  end

  // ---------------- checking / stimulus ----------------
  int n_cmp = 0, n_err = 0, n_ovf = 0;
  bit chk_en = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    ps2_byte  = b;
    ps2_valid = 1'b1;
  endtask

  task automatic idle_in();
    @(negedge clk);
    ps2_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || m_hold != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    n_cmp++;
    if (n >= 5000) begin
      n_err++;
      $display("FAIL wait_idle: got timeout expected drain within 5000 cycles");
    end
    @(negedge clk);
  endtask

  task automatic drive_pa(input logic [7:0] oe, input logic [7:0] o);
    pa_oe = oe; pa_out = o;
    @(negedge clk);
  endtask

  initial begin : p_main
    int ovf0;
    fork
      forever begin
        @(posedge clk);
        #1;
        if (chk_en) begin
          chk("pa_in", pa_in, exp_pa);
          chk("pb_in", pb_in, exp_pb);
          chk("restore_n", {7'b0, restore_n}, {7'b0, exp_rst_n});
          chk("fifo_ovf", {7'b0, fifo_ovf}, {7'b0, exp_ovf});
          if (fifo_ovf === 1'b1) n_ovf++;
        end
      end
      begin
        repeat (3) @(negedge clk);
        chk_en = 1;
        // 1: reset state
        chk("t1 pa_in", pa_in, 8'hFF);
        chk("t1 pb_in", pb_in, 8'hFF);
        chk("t1 restore_n", {7'b0, restore_n}, 8'h01);
        chk("t1 fifo_ovf", {7'b0, fifo_ovf}, 8'h00);
        res_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1 idle pb_in", pb_in, 8'hFF);

        // 2/3: press A then queue its release; release waits out the hold
        send(8'h1C); send(8'hF0); send(8'h1C); idle_in();
        drive_pa(8'hFF, 8'hFD);
        chk("t2 A col1 pb_in", pb_in, 8'hFB);
        drive_pa(8'hFF, 8'hFF);
        chk("t2 col idle pb_in", pb_in, 8'hFF);
        drive_pa(8'hFF, 8'hFD);
        repeat (40) @(negedge clk);
        chk("t3 still held pb_in", pb_in, 8'hFB);
        wait_idle();
        chk("t3 released pb_in", pb_in, 8'hFF);

        // typematic repeat and unmapped byte: no change
        send(8'h1C); send(8'h1C); send(8'h77); idle_in();
        wait_idle();
        chk("t2 repeat pb_in", pb_in, 8'hFB);
        send(8'hF0); send(8'h1C); idle_in();
        wait_idle();

        // 4: RESTORE
        send(8'hE0); send(8'h7D); idle_in();
        repeat (2) @(negedge clk);
        chk("t4 restore press", {7'b0, restore_n}, 8'h00);
        wait_idle();
        send(8'hE0); send(8'hF0); send(8'h7D); idle_in();
        wait_idle();
        chk("t4 restore release", {7'b0, restore_n}, 8'h01);
        send(8'hE0); send(8'h12); idle_in();
        wait_idle();
        chk("t4 fake shift", {7'b0, restore_n}, 8'h01);
        chk("t4 fake shift pb_in", pb_in, 8'hFF);

        // 5: overflow while hold active; byte 10 (J) dropped
        ovf0 = n_ovf;
        send(8'h1D);
        send(8'hF0); send(8'h1D); send(8'h1C); send(8'hF0);
        send(8'h1C); send(8'h25); send(8'hF0); send(8'h25);
        send(8'h3B);
        idle_in();
        wait_idle();
        chk("t5 ovf pulses", 8'(n_ovf - ovf0), 8'h01);
        drive_pa(8'hFF, 8'h00);
        chk("t5 all released pb_in", pb_in, 8'hFF);

        // joysticks
        drive_pa(8'h00, 8'hFF);
        joy2_n = 5'b01110; joy1_n = 5'b11101;
        @(negedge clk);
        chk("joy2 pa_in", pa_in, 8'hEE);
        chk("joy1 pb_in", pb_in, 8'hFD);
        joy2_n = 5'h1F; joy1_n = 5'h1F;

        // 6: ghost rectangle A(1,2) 4(1,3) J(4,2), drive col4
        send(8'h1C); send(8'h25); send(8'h3B); idle_in();
        wait_idle();
        drive_pa(8'hFF, 8'hEF);
`ifdef KBD_GHOSTING_EN
        chk("t6 ghost pb_in", pb_in, 8'hF3);
        chk("t6 ghost pa_in", pa_in, 8'hED);
`else
        chk("t6 plain pb_in", pb_in, 8'hFB);
        chk("t6 plain pa_in", pa_in, 8'hEF);
`endif

        // reset mid-sequence: keys cleared, E0 prefix lost
        send(8'hE0); idle_in();
        @(negedge clk);
        res_n = 1'b0;
        @(negedge clk);
        chk("rst mid pb_in", pb_in, 8'hFF);
        @(negedge clk);
        res_n = 1'b1;
        send(8'h7D); idle_in();
        wait_idle();
        chk("rst mid restore_n", {7'b0, restore_n}, 8'h01);
        drive_pa(8'hFF, 8'h00);
        chk("rst mid keys clear", pb_in, 8'hFF);
        repeat (2) @(negedge clk);
      end
    join_any
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
